// File: rtl/div_pkg.sv
// Shared constants and types for the iterative divide / HI-LO unit.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_hilo_unit_if.sv
// Execute-stage bus between control/datapath and the divide / HI-LO unit.
interface div_hilo_unit_if import div_pkg::*; #(
    parameter int unsigned WIDTH = DIV_WIDTH
) ();

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             mf_req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic             stall;

    modport master (
        output start, is_signed, dividend, divisor, hi_we, lo_we, wdata, mf_req,
        input  hi, lo, busy, done, div_by_zero, stall
    );

    modport slave (
        input  start, is_signed, dividend, divisor, hi_we, lo_we, wdata, mf_req,
        output hi, lo, busy, done, div_by_zero, stall
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left, subtract divisor if it fits.
module div_step import div_pkg::*; #(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    // One extra bit keeps the shifted remainder exact for divisors above 2^(WIDTH-1)
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        fits    = (shifted >= {1'b0, divisor});
        rem_out = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_out = {quo_in[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_hilo_unit.sv
// Iterative DIV/DIVU with architectural HI/LO registers and MTHI/MTLO/MFHI/MFLO support.
module div_hilo_unit import div_pkg::*; #(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    div_hilo_unit_if.slave bus
);

    localparam int unsigned CW = $clog2(WIDTH);

    div_state_e       state_q;
    div_state_e       state_d;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [CW-1:0]    cnt_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;

    logic             launch;
    logic             zero_div;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] quo_fix;

    // Operand magnitudes; the most negative value maps onto itself as an unsigned magnitude
    always_comb begin
        a_neg   = bus.is_signed & bus.dividend[WIDTH-1];
        b_neg   = bus.is_signed & bus.divisor[WIDTH-1];
        a_mag   = a_neg ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
        b_mag   = b_neg ? (~bus.divisor + WIDTH'(1)) : bus.divisor;
        quo_fix = q_neg_q ? (~quo_q + WIDTH'(1)) : quo_q;
        rem_fix = r_neg_q ? (~rem_q + WIDTH'(1)) : rem_q;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvsr_q),
        .rem_out (rem_step),
        .quo_out (quo_step)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        launch   = 1'b0;
        zero_div = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        zero_div = 1'b1;
                    end else begin
                        launch  = 1'b1;
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath, HI/LO and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            busy_q <= (state_d != IDLE);
            done_q <= (state_q == FIX) | zero_div;
            dbz_q  <= zero_div;

            if (launch) begin
                rem_q   <= '0;
                quo_q   <= a_mag;
                dvsr_q  <= b_mag;
                cnt_q   <= CW'(WIDTH - 1);
                q_neg_q <= a_neg ^ b_neg;
                r_neg_q <= a_neg;
            end else if (state_q == ITER) begin
                rem_q <= rem_step;
                quo_q <= quo_step;
                cnt_q <= cnt_q - CW'(1);
            end

            if (state_q == FIX) begin
                hi_q <= rem_fix;
                lo_q <= quo_fix;
            end else if (state_q == IDLE) begin
                if (bus.hi_we) begin
                    hi_q <= bus.wdata;
                end
                if (bus.lo_we) begin
                    lo_q <= bus.wdata;
                end
            end
        end
    end

    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.stall       = busy_q & (bus.start | bus.mf_req | bus.hi_we | bus.lo_we);

endmodule
